redmule_job_ctx: RTL and testbench

REDMULE_JOB_CTX -- requirements
Module: redmule_job_ctx

---
 rtl/redmule_job_ctx_if.sv | 37 +++
 rtl/redmule_job_ctx.sv | 103 ++++++++++
 tb/tb_redmule_job_ctx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/redmule_job_ctx_if.sv
// Bus bundle between the configuration/engine side and the RedMulE job-context queue.
// The master drives staging writes, triggers and the engine ready; the slave is the queue.
interface redmule_job_ctx_if #(
    parameter int N_CONTEXT = 2,
    parameter int N_REGS    = 19,
    parameter int ID_W      = 8
);
    localparam int IDX_W = $clog2(N_REGS);
    localparam int CNT_W = $clog2(N_CONTEXT) + 1;

    logic                         cfg_we_i;
    logic [IDX_W-1:0]             cfg_idx_i;
    logic [31:0]                  cfg_wdata_i;
    logic [31:0]                  cfg_rdata_o;
    logic                         trigger_i;
    logic                         trigger_err_o;
    logic [ID_W-1:0]              job_id_o;
    logic                         job_valid_o;
    logic                         job_ready_i;
    logic [N_REGS-1:0][31:0]      job_regs_o;
    logic [ID_W-1:0]              job_head_id_o;
    logic                         full_o;
    logic                         empty_o;
    logic [CNT_W-1:0]             pending_o;

    modport master (
        output cfg_we_i, cfg_idx_i, cfg_wdata_i, trigger_i, job_ready_i,
        input  cfg_rdata_o, trigger_err_o, job_id_o, job_valid_o, job_regs_o,
               job_head_id_o, full_o, empty_o, pending_o
    );

    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_wdata_i, trigger_i, job_ready_i,
        output cfg_rdata_o, trigger_err_o, job_id_o, job_valid_o, job_regs_o,
               job_head_id_o, full_o, empty_o, pending_o
    );
endinterface

// File: rtl/redmule_job_ctx.sv
// Job-context queue for RedMulE: a staging register bank is committed on trigger into a
// small circular queue of contexts, each tagged with a rolling job ID, popped by the engine.
module redmule_job_ctx #(
    parameter int N_CONTEXT = 2,
    parameter int N_REGS    = 19,
    parameter int ID_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    redmule_job_ctx_if.slave      bus
);
    localparam int PTR_W = $clog2(N_CONTEXT);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [N_REGS-1:0][31:0] regs_t;

    regs_t             staging_q;
    regs_t             staging_next;
    regs_t             slot_regs_q [N_CONTEXT];
    logic [ID_W-1:0]   slot_id_q   [N_CONTEXT];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ID_W-1:0]   job_id_q;
    logic              trigger_err_q;

    logic              idx_ok;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;

    assign idx_ok = 32'(bus.cfg_idx_i) < N_REGS;
    assign full   = count_q == CNT_W'(N_CONTEXT);
    assign empty  = count_q == '0;
    assign pop    = !empty && bus.job_ready_i;
    // A full queue still accepts a trigger when the head leaves in the same cycle.
    assign push   = bus.trigger_i && (!full || pop);

    // Same-cycle staging write is folded into the committed context.
    always_comb begin
        staging_next = staging_q;
        if (bus.cfg_we_i && idx_ok) begin
            staging_next[bus.cfg_idx_i] = bus.cfg_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staging_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            job_id_q      <= '0;
            trigger_err_q <= 1'b0;
            for (int i = 0; i < N_CONTEXT; i++) begin
                slot_regs_q[i] <= '0;
                slot_id_q[i]   <= '0;
            end
        end else if (clear_i) begin
            staging_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            job_id_q      <= '0;
            trigger_err_q <= 1'b0;
            for (int i = 0; i < N_CONTEXT; i++) begin
                slot_regs_q[i] <= '0;
                slot_id_q[i]   <= '0;
            end
        end else begin
            staging_q     <= staging_next;
            trigger_err_q <= bus.trigger_i && !push;
            if (push) begin
                slot_regs_q[wr_ptr_q] <= staging_next;
                slot_id_q[wr_ptr_q]   <= job_id_q + ID_W'(1);
                job_id_q              <= job_id_q + ID_W'(1);
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // Occupancy is tracked explicitly so equal pointers are never ambiguous.
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.cfg_rdata_o   = idx_ok ? staging_q[bus.cfg_idx_i] : 32'h0;
    assign bus.trigger_err_o = trigger_err_q;
    assign bus.job_id_o      = job_id_q;
    assign bus.job_valid_o   = !empty;
    assign bus.job_regs_o    = slot_regs_q[rd_ptr_q];
    assign bus.job_head_id_o = slot_id_q[rd_ptr_q];
    assign bus.full_o        = full;
    assign bus.empty_o       = empty;
    assign bus.pending_o     = count_q;

endmodule

// File: tb/tb_redmule_job_ctx.sv
// Self-checking bench for redmule_job_ctx: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_redmule_job_ctx;
    localparam int NC   = 2;
    localparam int NR   = 19;
    localparam int IDW  = 8;

    logic clk;
    logic rst_n;
    logic clear;

    redmule_job_ctx_if #(.N_CONTEXT(NC), .N_REGS(NR), .ID_W(IDW)) dif ();

    redmule_job_ctx #(.N_CONTEXT(NC), .N_REGS(NR), .ID_W(IDW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .bus     (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [NR-1:0][31:0] regs_t;
    typedef struct packed {
        regs_t          regs;
        logic [IDW-1:0] id;
    } job_t;

    regs_t          m_stage;
    job_t           mq[$];
    logic [IDW-1:0] m_id;
    logic           m_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic        trig;
        logic        rdy;
        logic        clr;
        logic        exp_valid;
        logic [1:0]  exp_pend;
        logic [7:0]  exp_head;
        logic [7:0]  exp_jid;
        logic        exp_err;
        logic        exp_full;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];

    task automatic model_reset();
        m_stage = '0;
        mq.delete();
        m_id  = '0;
        m_err = 1'b0;
    endtask

    // Reference behaviour for one rising edge given the inputs that were applied.
    task automatic model_step(input logic we, input int idx, input logic [31:0] wd,
                              input logic trig, input logic rdy, input logic clr);
        regs_t staged;
        bit    do_pop;
        bit    do_push;
        if (clr) begin
            model_reset();
            return;
        end
        staged = m_stage;
        if (we && idx < NR) staged[idx] = wd;
        do_pop  = (mq.size() > 0) && rdy;
        do_push = trig && ((mq.size() < NC) || do_pop);
        if (do_pop) mq.delete(0);
        if (do_push) begin
            m_id = m_id + 8'd1;
            mq.push_back('{regs: staged, id: m_id});
        end
        m_err   = trig && !do_push;
        m_stage = staged;
    endtask

    task automatic check_val(input string name, input logic [NR*32-1:0] act,
                             input logic [NR*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag);
        int          idx;
        logic [31:0] exp_rd;
        idx    = int'(dif.cfg_idx_i);
        exp_rd = (idx < NR) ? m_stage[idx] : 32'h0;
        check_val({tag, " rdata"},   NR*32'(dif.cfg_rdata_o),   NR*32'(exp_rd));
        check_val({tag, " valid"},   NR*32'(dif.job_valid_o),   NR*32'(mq.size() > 0));
        check_val({tag, " empty"},   NR*32'(dif.empty_o),       NR*32'(mq.size() == 0));
        check_val({tag, " full"},    NR*32'(dif.full_o),        NR*32'(mq.size() == NC));
        check_val({tag, " pending"}, NR*32'(dif.pending_o),     NR*32'(mq.size()));
        check_val({tag, " job_id"},  NR*32'(dif.job_id_o),      NR*32'(m_id));
        check_val({tag, " err"},     NR*32'(dif.trigger_err_o), NR*32'(m_err));
        if (mq.size() > 0) begin
            check_val({tag, " head_id"}, NR*32'(dif.job_head_id_o), NR*32'(mq[0].id));
            check_val({tag, " regs"},    dif.job_regs_o,            mq[0].regs);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
    task automatic apply_stimulus(input logic we, input logic [4:0] idx, input logic [31:0] wd,
                                  input logic trig, input logic rdy, input logic clr);
        dif.cfg_we_i    = we;
        dif.cfg_idx_i   = idx;
        dif.cfg_wdata_i = wd;
        dif.trigger_i   = trig;
        dif.job_ready_i = rdy;
        clear           = clr;
        @(posedge clk);
        model_step(we, int'(idx), wd, trig, rdy, clr);
        #1;
        dif.cfg_we_i    = 1'b0;
        dif.trigger_i   = 1'b0;
        dif.job_ready_i = 1'b0;
        clear           = 1'b0;
    endtask

    initial begin
        string t;
        vecs[0]  = '{1'b1, 5'd0,  32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 32'h1000};
        vecs[1]  = '{1'b1, 5'd18, 32'hA5,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 32'hA5};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 8'd1, 1'b0, 1'b0, 32'h1000};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1, 8'd2, 1'b0, 1'b1, 32'h1000};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1, 8'd2, 1'b1, 1'b1, 32'h1000};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1, 8'd2, 1'b0, 1'b1, 32'h1000};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd2, 8'd3, 1'b0, 1'b1, 32'h1000};
        vecs[7]  = '{1'b1, 5'd4,  32'h7,    1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'd3, 8'd4, 1'b0, 1'b1, 32'h7};
        vecs[8]  = '{1'b0, 5'd4,  32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd4, 8'd4, 1'b0, 1'b0, 32'h7};
        vecs[9]  = '{1'b1, 5'd25, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd4, 8'd4, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 5'd4,  32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd4, 8'd4, 1'b0, 1'b0, 32'h7};
        vecs[11] = '{1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd4, 1'b0, 1'b0, 32'h1000};
        vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd4, 1'b0, 1'b0, 32'h1000};
        vecs[13] = '{1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 5'd18, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0, 32'h0};

        rst_n           = 1'b0;
        clear           = 1'b0;
        dif.cfg_we_i    = 1'b0;
        dif.cfg_idx_i   = '0;
        dif.cfg_wdata_i = '0;
        dif.trigger_i   = 1'b0;
        dif.job_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_output("reset");

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].idx, vecs[i].wdata,
                           vecs[i].trig, vecs[i].rdy, vecs[i].clr);
            t = $sformatf("vec%0d", i);
            check_val({t, " tbl_valid"}, NR*32'(dif.job_valid_o),   NR*32'(vecs[i].exp_valid));
            check_val({t, " tbl_pend"},  NR*32'(dif.pending_o),     NR*32'(vecs[i].exp_pend));
            check_val({t, " tbl_jid"},   NR*32'(dif.job_id_o),      NR*32'(vecs[i].exp_jid));
            check_val({t, " tbl_err"},   NR*32'(dif.trigger_err_o), NR*32'(vecs[i].exp_err));
            check_val({t, " tbl_full"},  NR*32'(dif.full_o),        NR*32'(vecs[i].exp_full));
            check_val({t, " tbl_rdata"}, NR*32'(dif.cfg_rdata_o),   NR*32'(vecs[i].exp_rdata));
            if (vecs[i].exp_valid)
                check_val({t, " tbl_head"}, NR*32'(dif.job_head_id_o), NR*32'(vecs[i].exp_head));
            check_output(t);
        end

        // Job ID wrap: 256 accepted triggers while the engine drains continuously.
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b1, 5'(i % NR), $urandom, 1'b1, 1'b1, 1'b0);
            if (i == 254) check_val("id_255", NR*32'(dif.job_id_o), NR*32'(8'd255));
        end
        check_val("id_wrap", NR*32'(dif.job_id_o), NR*32'(8'd0));
        check_output("wrap");
        apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_val("pre_rst_pend", NR*32'(dif.pending_o), NR*32'(2));

        // Asynchronous reset mid-cycle with two jobs queued.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_empty", NR*32'(dif.empty_o),     NR*32'(1));
        check_val("async_valid", NR*32'(dif.job_valid_o), NR*32'(0));
        check_output("async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("post_rst%0d", i));
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 63) == 0));
            check_output($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
